// File: rtl/inst_word_decoder.sv
// inst_word_decoder: splits the 16-bit instruction word into a data-load immediate
// or ALU/destination/jump controls. Valid/ready in and out, registered output
// with a one-entry skid buffer for full throughput at one cycle of latency.
module inst_word_decoder #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      inst_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             is_data,
  output logic [15:0]      imm,
  output logic             sm,
  output logic [5:0]       opc,
  output logic [2:0]       dst,
  output logic [2:0]       jmp,
  output logic             jmp_always,
  output logic             no_effect,
  output logic             rsv_nz,
  output logic [CNT_W-1:0] dec_count
);

  localparam int unsigned IMM_W = 16;
  localparam int unsigned OPC_W = 6;
  localparam int unsigned DST_W = 3;
  localparam int unsigned JMP_W = 3;
  localparam int unsigned IGN_W = 2;

  // Instruction word layout: [15]kind [14:13]ignored [12]sm [11:6]opc [5:3]dst [2:0]j
  typedef struct packed {
    logic             kind;
    logic [IGN_W-1:0] ignored;
    logic             sm;
    logic [OPC_W-1:0] opc;
    logic [DST_W-1:0] dst;
    logic [JMP_W-1:0] jmp;
  } inst_word_t;

  // Decoded control bundle held in the main and skid registers
  typedef struct packed {
    logic             is_data;
    logic [IMM_W-1:0] imm;
    logic             sm;
    logic [OPC_W-1:0] opc;
    logic [DST_W-1:0] dst;
    logic [JMP_W-1:0] jmp;
    logic             jmp_always;
    logic             no_effect;
    logic             rsv_nz;
  } dec_t;

  // Buffer occupancy: nothing held, main only, main and skid both full
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [DST_W-1:0] DST_WRITE_A = 3'b100;
  localparam logic [JMP_W-1:0] JMP_ALL     = 3'b111;

  inst_word_t       word;
  dec_t             dec_c;
  dec_t             m_q;
  dec_t             s_q;
  state_t           state_q;
  state_t           state_n;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] count_q;
  logic             in_xfer_c;
  logic             out_xfer_c;
  logic             ld_m_in_c;
  logic             ld_m_s_c;
  logic             ld_s_c;

  assign word       = inst_word;
  assign in_xfer_c  = in_valid && in_ready_q;
  assign out_xfer_c = out_valid_q && out_ready;

  // Combinational field decode of the incoming word
  always_comb begin
    dec_c = '0;
    if (!word.kind) begin
      dec_c.is_data = 1'b1;
      dec_c.imm     = {1'b0, inst_word[IMM_W-2:0]};
      dec_c.dst     = DST_WRITE_A;
    end else begin
      dec_c.sm         = word.sm;
      dec_c.opc        = word.opc;
      dec_c.dst        = word.dst;
      dec_c.jmp        = word.jmp;
      dec_c.jmp_always = (word.jmp == JMP_ALL);
      dec_c.no_effect  = (word.dst == '0) && (word.jmp == '0);
      dec_c.rsv_nz     = (word.ignored != '0);
    end
  end

  // Occupancy next-state and register load selects
  always_comb begin
    state_n   = state_q;
    ld_m_in_c = 1'b0;
    ld_m_s_c  = 1'b0;
    ld_s_c    = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer_c) begin
          ld_m_in_c = 1'b1;
          state_n   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_xfer_c) begin
          if (in_xfer_c) begin
            ld_m_in_c = 1'b1;
          end else begin
            state_n = ST_EMPTY;
          end
        end else if (in_xfer_c) begin
          ld_s_c  = 1'b1;
          state_n = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_xfer_c) begin
          ld_m_s_c = 1'b1;
          state_n  = ST_HOLD;
        end
      end
      default: begin
        state_n = ST_EMPTY;
      end
    endcase
  end

  // Occupancy state and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      in_ready_q  <= (state_n != ST_FULL);
      out_valid_q <= (state_n != ST_EMPTY);
    end
  end

  // Main register: refill from skid first so ordering stays FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= '0;
    end else if (ld_m_s_c) begin
      m_q <= s_q;
    end else if (ld_m_in_c) begin
      m_q <= dec_c;
    end
  end

  // Skid register: catches the word accepted while main is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
    end else if (ld_s_c) begin
      s_q <= dec_c;
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (out_xfer_c) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign is_data    = m_q.is_data;
  assign imm        = m_q.imm;
  assign sm         = m_q.sm;
  assign opc        = m_q.opc;
  assign dst        = m_q.dst;
  assign jmp        = m_q.jmp;
  assign jmp_always = m_q.jmp_always;
  assign no_effect  = m_q.no_effect;
  assign rsv_nz     = m_q.rsv_nz;
  assign dec_count  = count_q;

endmodule

// File: tb/tb_inst_word_decoder.sv
// Directed bench for inst_word_decoder: decode table, stall/skid, reset, counter wrap.
module tb_inst_word_decoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] inst_word;

  logic        in_ready, out_valid, is_data, sm, jmp_always, no_effect, rsv_nz;
  logic [15:0] imm;
  logic [5:0]  opc;
  logic [2:0]  dst, jmp;
  logic [31:0] dec_count;

  logic        in_ready4, out_valid4, is_data4, sm4, jmp_always4, no_effect4, rsv_nz4;
  logic [15:0] imm4;
  logic [5:0]  opc4;
  logic [2:0]  dst4, jmp4;
  logic [3:0]  dec_count4;

  int n_chk;
  int n_fail;

  inst_word_decoder #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst_word(inst_word), .out_valid(out_valid), .out_ready(out_ready),
    .is_data(is_data), .imm(imm), .sm(sm), .opc(opc), .dst(dst), .jmp(jmp),
    .jmp_always(jmp_always), .no_effect(no_effect), .rsv_nz(rsv_nz),
    .dec_count(dec_count)
  );

  inst_word_decoder #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .inst_word(inst_word), .out_valid(out_valid4), .out_ready(out_ready),
    .is_data(is_data4), .imm(imm4), .sm(sm4), .opc(opc4), .dst(dst4), .jmp(jmp4),
    .jmp_always(jmp_always4), .no_effect(no_effect4), .rsv_nz(rsv_nz4),
    .dec_count(dec_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic        is_data;
    logic [15:0] imm;
    logic        sm;
    logic [5:0]  opc;
    logic [2:0]  dst;
    logic [2:0]  jmp;
    logic        jmp_always;
    logic        no_effect;
    logic        rsv_nz;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_vec(input string tag, input vec_t v);
    chk({tag, ".out_valid"},  32'(out_valid),  32'(1'b1));
    chk({tag, ".is_data"},    32'(is_data),    32'(v.is_data));
    chk({tag, ".imm"},        32'(imm),        32'(v.imm));
    chk({tag, ".sm"},         32'(sm),         32'(v.sm));
    chk({tag, ".opc"},        32'(opc),        32'(v.opc));
    chk({tag, ".dst"},        32'(dst),        32'(v.dst));
    chk({tag, ".jmp"},        32'(jmp),        32'(v.jmp));
    chk({tag, ".jmp_always"}, 32'(jmp_always), 32'(v.jmp_always));
    chk({tag, ".no_effect"},  32'(no_effect),  32'(v.no_effect));
    chk({tag, ".rsv_nz"},     32'(rsv_nz),     32'(v.rsv_nz));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    inst_word = 16'h0000;

    //              word      dat imm       sm opc        dst     jmp     ja  ne  rsv
    vecs[0] = '{16'h7FFF, 1'b1, 16'h7FFF, 1'b0, 6'b000000, 3'b100, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h8397, 1'b0, 16'h0000, 1'b0, 6'b001110, 3'b010, 3'b111, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'hE000, 1'b0, 16'h0000, 1'b0, 6'b000000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{16'h0000, 1'b1, 16'h0000, 1'b0, 6'b000000, 3'b100, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'hFFFF, 1'b0, 16'h0000, 1'b1, 6'b111111, 3'b111, 3'b111, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{16'h1234, 1'b1, 16'h1234, 1'b0, 6'b000000, 3'b100, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'h9000, 1'b0, 16'h0000, 1'b1, 6'b000000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{16'hA0C2, 1'b0, 16'h0000, 1'b0, 6'b000011, 3'b000, 3'b010, 1'b0, 1'b0, 1'b1};

    // Reset state
    do_reset();
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    chk("rst.dec_count", dec_count,      32'd0);
    chk("rst.is_data",   32'(is_data),   32'd0);
    chk("rst.imm",       32'(imm),       32'd0);
    chk("rst.dst",       32'(dst),       32'd0);

    // Back-to-back decode table, one output per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid  = 1'b1;
      inst_word = vecs[i].word;
      chk($sformatf("stream%0d.in_ready", i), 32'(in_ready), 32'd1);
      step();
      chk_vec($sformatf("vec%0d", i), vecs[i]);
    end
    in_valid = 1'b0;
    step();
    chk("stream.drained",   32'(out_valid), 32'd0);
    chk("stream.dec_count", dec_count,      32'd8);

    // Stall: fill main and skid, hold, then drain in order
    out_ready = 1'b0;
    in_valid  = 1'b1;
    inst_word = 16'h0011;
    step();
    chk("stall.m_valid",   32'(out_valid), 32'd1);
    chk("stall.m_imm",     32'(imm),       32'h0011);
    chk("stall.in_ready1", 32'(in_ready),  32'd1);
    inst_word = 16'h0022;
    step();
    chk("stall.in_ready0", 32'(in_ready),  32'd0);
    chk("stall.hold_imm",  32'(imm),       32'h0011);
    inst_word = 16'h0033;
    step();
    chk("stall.in_ready0b", 32'(in_ready), 32'd0);
    chk("stall.stable_imm", 32'(imm),      32'h0011);
    chk("stall.stable_ov",  32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    chk("drain.imm_b",    32'(imm),      32'h0022);
    chk("drain.in_ready", 32'(in_ready), 32'd1);
    step();
    chk("drain.imm_c",    32'(imm),       32'h0033);
    chk("drain.ov_c",     32'(out_valid), 32'd1);
    in_valid = 1'b0;
    step();
    chk("drain.empty",     32'(out_valid), 32'd0);
    chk("drain.dec_count", dec_count,      32'd11);

    // Reset with skid full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    inst_word = 16'h0044;
    step();
    inst_word = 16'h0055;
    step();
    chk("rstfull.in_ready0", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    chk("rstfull.out_valid", 32'(out_valid), 32'd0);
    chk("rstfull.in_ready",  32'(in_ready),  32'd1);
    chk("rstfull.dec_count", dec_count,      32'd0);
    chk("rstfull.imm",       32'(imm),       32'd0);
    step();
    chk("rstfull.stay_empty", 32'(out_valid), 32'd0);

    // Counter wrap: 17 transfers on a 4-bit counter
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid  = 1'b1;
      inst_word = 16'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("wrap.dec_count4", 32'(dec_count4), 32'd1);
    chk("wrap.dec_count",  dec_count,       32'd17);
    chk("wrap.last_imm",   32'(imm),        32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
